imm_encoder: RTL and testbench
==============================

# imm_encoder

Pipelined RISC-V immediate encoder and instruction-memory writer: it is the inverse of the decode-side immediate extender. It accepts a base instruction word, a 32-bit immediate and an immediate type, then scatters the immediate into the type's bit fields and range-checks it. It emits the assembled word with an auto-incrementing instruction-memory address over a valid/ready handshake, and is used by the boot/program loader to populate instruction memory.

## Interface
- IMMSRC_WIDTH, 3, width of immediate-type select (same encoding as decode side)
- DATA_WIDTH, 32, instruction/immediate width; only 32 supported
- ADDR_WIDTH, 32, instruction-memory byte-address width
- ADDR_BASE, 0, first write address after reset/restart
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- restart  input  1  synchronous: reset address counter and error count
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_immsrc  input  IMMSRC_WIDTH  000 I, 001 U, 010 S, 011 B, 100 J, others invalid
- in_imm  input  DATA_WIDTH  immediate value (byte offset for B/J, full value for U)
- in_base  input  DATA_WIDTH  opcode/rd/rs/funct fields; immediate positions ignored
- out_valid  output  1  assembled word pending
- out_ready  input  1  memory accepts word when out_valid && out_ready
- out_instr  output  DATA_WIDTH  assembled instruction
- out_addr  output  ADDR_WIDTH  byte address for out_instr
- out_err  output  1  immediate not representable or invalid type
- err_count  output  8  saturating count of accepted requests with error

## Operation
- Field placement (all other bits from in_base):
  - I: instr[31:20]=imm[11:0]; legal iff imm[31:11] all equal
  - U: instr[31:12]=imm[31:12]; legal iff imm[11:0]==0
  - S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]; legal iff imm[31:11] all equal
  - B: instr[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; legal iff imm[31:12] all equal and imm[0]==0
  - J: instr[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; legal iff imm[31:20] all equal and imm[0]==0
  - Invalid type: out_instr=in_base unchanged, out_err=1
- Illegal immediate: fields still written with truncated bits as above; out_err=1.
- Single output register stage; in_ready = !out_valid || out_ready (combinational from out_ready, full throughput).
- Address counter addr_q: on accept, out_addr<=addr_q, addr_q<=addr_q+4, modulo 2^ADDR_WIDTH (wraps to 0, not to ADDR_BASE).
- err_count increments on each accepted request with error; saturates at 255.
- restart: addr_q<=ADDR_BASE, err_count<=0, out_valid<=0 (pending word dropped); in_ready=0 during restart cycle; no request accepted that cycle.

## Timing
- Reset (rst_n low, async): out_valid=0, out_instr=0, out_addr=0, out_err=0, err_count=0, addr_q=ADDR_BASE; in_ready=1 after reset since out_valid=0.
- Latency: request accepted at edge N appears on out_* after edge N, valid through cycle N+1.
- out_instr/out_addr/out_err stable while out_valid && !out_ready.
- Simultaneous output drain and input accept: new word replaces old in same edge, no bubble.
- rst_n deasserted mid-transfer: pending word lost, no partial state.
- restart and in_valid together: restart wins, request not accepted (in_ready=0).
- err_count at 255 with new error: stays 255.

## Test plan
- Reset, then I-type imm=0xFFFFFFFF base=0x00000013 -> out_instr=0xFFF00013, out_addr=ADDR_BASE, out_err=0, one cycle later.
- B-type imm=8 base=0x00000063 then J-type imm=2 base=0x0000006F back-to-back, out_ready=1 -> 0x00000463 @0, 0x0020006F @4, no bubble.
- U-type imm=0x12345000 base=0x00000037 -> 0x12345037, err=0; S-type imm=0x800 -> out_err=1, err_count=1; B-type imm=3 -> out_err=1; immsrc=111 -> out_instr=base, err.
- out_ready held low 5 cycles with in_valid high -> in_ready=0, outputs stable, single word delivered on release, next word follows at +4.
- ADDR_WIDTH=4, ADDR_BASE=8: five accepts -> addresses 8,12,0,4,8; restart mid-stream -> next address 8, err_count=0, pending word dropped.
- 260 illegal requests -> err_count saturates at 255; async rst_n pulse mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/imm_encoder.sv
// RISC-V immediate encoder: scatters an immediate into a base instruction word,
// range-checks it, and emits the word with an auto-incrementing imem address.
module imm_encoder #(
   parameter int                    IMMSRC_WIDTH = 3,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] ADDR_BASE    = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    restart,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IMMSRC_WIDTH-1:0] in_immsrc,
   input  logic [DATA_WIDTH-1:0]   in_imm,
   input  logic [DATA_WIDTH-1:0]   in_base,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_instr,
   output logic [ADDR_WIDTH-1:0]   out_addr,
   output logic                    out_err,
   output logic [7:0]              err_count
);

   typedef enum logic [IMMSRC_WIDTH-1:0] {
      IMM_I = IMMSRC_WIDTH'(0),
      IMM_U = IMMSRC_WIDTH'(1),
      IMM_S = IMMSRC_WIDTH'(2),
      IMM_B = IMMSRC_WIDTH'(3),
      IMM_J = IMMSRC_WIDTH'(4)
   } imm_type_e;

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
   logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
   logic                  out_err_q, out_err_d;
   logic [7:0]            err_count_q, err_count_d;

   logic [DATA_WIDTH-1:0] enc_instr;
   logic                  enc_err;
   logic                  accept;

   // Fields not owned by the immediate pass through from in_base untouched.
   always_comb begin
      enc_instr = in_base;
      enc_err   = 1'b0;
      case (in_immsrc)
         IMM_I: begin
            enc_instr[31:20] = in_imm[11:0];
            enc_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
         end
         IMM_U: begin
            enc_instr[31:12] = in_imm[31:12];
            enc_err = |in_imm[11:0];
         end
         IMM_S: begin
            enc_instr[31:25] = in_imm[11:5];
            enc_instr[11:7]  = in_imm[4:0];
            enc_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
         end
         IMM_B: begin
            enc_instr[31]    = in_imm[12];
            enc_instr[30:25] = in_imm[10:5];
            enc_instr[11:8]  = in_imm[4:1];
            enc_instr[7]     = in_imm[11];
            enc_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
         end
         IMM_J: begin
            enc_instr[31]    = in_imm[20];
            enc_instr[30:21] = in_imm[10:1];
            enc_instr[20]    = in_imm[11];
            enc_instr[19:12] = in_imm[19:12];
            enc_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
         end
         default: enc_err = 1'b1;
      endcase
   end

   assign in_ready = !restart && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // Drain and accept may share an edge: the new word overwrites the old one.
   always_comb begin
      addr_d      = addr_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_addr_d  = out_addr_q;
      out_err_d   = out_err_q;
      err_count_d = err_count_q;
      if (restart) begin
         addr_d      = ADDR_BASE;
         err_count_d = '0;
         out_valid_d = 1'b0;
      end else begin
         if (out_ready) begin
            out_valid_d = 1'b0;
         end
         if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_instr;
            out_addr_d  = addr_q;
            out_err_d   = enc_err;
            addr_d      = addr_q + ADDR_WIDTH'(4);
            if (enc_err && (err_count_q != '1)) begin
               err_count_d = err_count_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q      <= ADDR_BASE;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_addr_q  <= '0;
         out_err_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         addr_q      <= addr_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_addr_q  <= out_addr_d;
         out_err_q   <= out_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_addr  = out_addr_q;
   assign out_err   = out_err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder with a small address space to exercise wrap.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        restart;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_immsrc;
   logic [31:0] in_imm;
   logic [31:0] in_base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [3:0]  out_addr;
   logic        out_err;
   logic [7:0]  err_count;

   logic        rnd_mode    = 1'b0;
   logic        rnd_bit     = 1'b1;
   logic        ready_force = 1'b1;
   logic        done        = 1'b0;
   int          drv_timeouts = 0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   imm_encoder #(
      .IMMSRC_WIDTH(3),
      .DATA_WIDTH(32),
      .ADDR_WIDTH(4),
      .ADDR_BASE(4'd8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .restart(restart),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_immsrc(in_immsrc),
      .in_imm(in_imm),
      .in_base(in_base),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_addr(out_addr),
      .out_err(out_err),
      .err_count(err_count)
   );

   assign out_ready = rnd_mode ? rnd_bit : ready_force;

   always @(posedge clk) begin
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
   end

   // Reference model: legality by signed range, placement by shift-and-mask.
   function automatic logic [32:0] model(input logic [2:0] s, input logic [31:0] imm,
                                         input logic [31:0] base);
      longint v;
      logic   e;
      logic [31:0] w;
      v = longint'($signed(imm));
      case (s)
         3'd0: begin
            e = (v < -2048) || (v > 2047);
            w = (base & 32'h000F_FFFF) | (imm << 20);
         end
         3'd1: begin
            e = (imm % 32'd4096) != 0;
            w = (base & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
         end
         3'd2: begin
            e = (v < -2048) || (v > 2047);
            w = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
         end
         3'd3: begin
            e = (v < -4096) || (v > 4095) || ((imm % 32'd2) != 0);
            w = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
              | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
              | (((imm >> 11) & 32'h1) << 7);
         end
         3'd4: begin
            e = (v < -64'sd1048576) || (v > 64'sd1048575) || ((imm % 32'd2) != 0);
            w = (base & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31)
              | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
              | (imm & 32'h000F_F000);
         end
         default: begin
            e = 1'b1;
            w = base;
         end
      endcase
      return {e, w};
   endfunction

   typedef struct packed {
      logic [31:0] instr;
      logic [3:0]  addr;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [3:0]  m_addr   = 4'd8;
   int          m_errcnt = 0;
   int          seen_to  = 0;
   logic        stall    = 1'b0;
   exp_t        snap;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [32:0] m;
      if (drv_timeouts != seen_to) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got %0d timeouts expected 0", drv_timeouts);
         seen_to = drv_timeouts;
      end
      if (!rst_n) begin
         chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_out_instr", out_instr, 32'd0);
         chk("rst_out_addr", {28'd0, out_addr}, 32'd0);
         chk("rst_out_err", {31'd0, out_err}, 32'd0);
         chk("rst_err_count", {24'd0, err_count}, 32'd0);
         m_addr   = 4'd8;
         m_errcnt = 0;
         stall    = 1'b0;
         sb_q.delete();
      end else begin
         chk("err_count", {24'd0, err_count}, 32'(m_errcnt));
         chk("in_ready", {31'd0, in_ready}, {31'd0, !restart && (!out_valid || out_ready)});
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: got instr 0x%0h with empty scoreboard", out_instr);
            end else begin
               e = sb_q.pop_front();
               chk("out_instr", out_instr, e.instr);
               chk("out_addr", {28'd0, out_addr}, {28'd0, e.addr});
               chk("out_err", {31'd0, out_err}, {31'd0, e.err});
            end
         end
         if (out_valid && !out_ready) begin
            if (stall) begin
               chk("stall_instr", out_instr, snap.instr);
               chk("stall_addr", {28'd0, out_addr}, {28'd0, snap.addr});
               chk("stall_err", {31'd0, out_err}, {31'd0, snap.err});
            end
            snap  = '{instr: out_instr, addr: out_addr, err: out_err};
            stall = 1'b1;
         end else begin
            stall = 1'b0;
         end
         if (restart) begin
            m_addr   = 4'd8;
            m_errcnt = 0;
            sb_q.delete();
         end else if (in_valid && in_ready) begin
            m = model(in_immsrc, in_imm, in_base);
            sb_q.push_back('{instr: m[31:0], addr: m_addr, err: m[32]});
            m_addr = m_addr + 4'd4;
            if (m[32] && m_errcnt < 255) m_errcnt++;
         end
         if (done) begin
            chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
         end
      end
   end

   task automatic send(input logic [2:0] s, input logic [31:0] imm, input logic [31:0] base);
      int   n;
      logic got;
      in_valid  = 1'b1;
      in_immsrc = s;
      in_imm    = imm;
      in_base   = base;
      n   = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!got) drv_timeouts++;
   endtask

   task automatic idle(input int cycles);
      in_valid = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [31:0] imm;
      rst_n     = 1'b0;
      restart   = 1'b0;
      in_valid  = 1'b0;
      in_immsrc = '0;
      in_imm    = '0;
      in_base   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      send(3'd0, 32'hFFFF_FFFF, 32'h0000_0013);
      idle(2);
      send(3'd3, 32'd8, 32'h0000_0063);
      send(3'd4, 32'd2, 32'h0000_006F);
      idle(2);
      send(3'd1, 32'h1234_5000, 32'h0000_0037);
      send(3'd2, 32'h0000_0800, 32'h0000_0023);
      send(3'd3, 32'd3, 32'h0000_0063);
      send(3'd7, 32'h0000_0004, 32'hDEAD_BEEF);
      idle(2);

      // Backpressure: second request held while out_ready is low.
      ready_force = 1'b0;
      send(3'd0, 32'd5, 32'h0000_0013);
      fork
         send(3'd2, 32'h10, 32'h0000_2023);
         begin
            repeat (5) @(posedge clk);
            #1;
            ready_force = 1'b1;
         end
      join
      idle(3);

      // Restart with a word pending and a request presented: both dropped/refused.
      ready_force = 1'b0;
      send(3'd0, 32'd1, 32'h0000_0093);
      in_valid  = 1'b1;
      in_immsrc = 3'd1;
      in_imm    = 32'hABCD_E000;
      in_base   = 32'h0000_00B7;
      restart   = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
      send(3'd1, 32'hABCD_E000, 32'h0000_00B7);
      ready_force = 1'b1;
      idle(3);

      rnd_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: imm = 32'($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000;
            default: imm = $urandom & 32'hFFFF_F000;
         endcase
         if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
         send(3'($urandom_range(0, 7)), imm, $urandom);
         if ($urandom_range(0, 7) == 0) idle(1);
      end
      rnd_mode = 1'b0;
      ready_force = 1'b1;
      idle(3);

      for (int i = 0; i < 260; i++) begin
         send(3'd2, 32'h0000_0800, 32'h0000_0023);
      end
      idle(3);

      // Asynchronous reset with a stalled word pending.
      ready_force = 1'b0;
      send(3'd0, 32'd7, 32'h0000_0013);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready_force = 1'b1;
      idle(1);
      send(3'd4, 32'hFFFF_FFFE, 32'h0000_00EF);
      send(3'd0, 32'd2047, 32'h0000_0013);
      idle(5);
      done = 1'b1;
   end

endmodule
